// File: rtl/dtree_mc.sv
// Multi-channel oblique decision-tree classifier: per-channel sample windows,
// register-held node parameters and one shared MAC walking the tree.
module dtree_mc #(
  parameter int FEATURES    = 3,
  parameter int DEPTH       = 3,
  parameter int CHANNELS    = 4,
  parameter int IN_WIDTH    = 10,
  parameter int COEFF_WIDTH = 4,
  localparam int NODES = (2 ** DEPTH) - 1,
  localparam int WORDS = NODES * (FEATURES + 1),
  localparam int CHW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int AW    = $clog2(WORDS),
  localparam int LW    = $clog2(DEPTH + 1),
  localparam int NW    = DEPTH + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CHW-1:0]        in_channel,
  input  logic [IN_WIDTH-1:0]   sample,
  input  logic                  cfg_we,
  output logic                  cfg_ready,
  input  logic [AW-1:0]         cfg_addr,
  input  logic [IN_WIDTH:0]     cfg_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CHW-1:0]        out_channel,
  output logic [DEPTH-1:0]      out_path,
  output logic [LW-1:0]         out_level,
  output logic [NW-1:0]         out_node
);

  localparam int ACCW = IN_WIDTH + 2 + $clog2(FEATURES);
  localparam int PW   = IN_WIDTH + COEFF_WIDTH;
  localparam int KW   = (FEATURES > 1) ? $clog2(FEATURES) : 1;
  localparam int NIW  = (NODES > 1) ? $clog2(NODES) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, MAC, DECIDE, OUT} state_t;

  state_t                      state_q, state_d;
  logic signed [COEFF_WIDTH-1:0] coeff_q [NODES][FEATURES];
  logic signed [IN_WIDTH-1:0]  bias_q [NODES];
  logic [NODES-1:0]            leaf_q;
  logic signed [IN_WIDTH-1:0]  win_q [CHANNELS][FEATURES];
  logic signed [ACCW-1:0]      acc_q, acc_d;
  logic [NW-1:0]               node_q, node_d;
  logic [LW-1:0]               level_q, level_d;
  logic [DEPTH-1:0]            path_q, path_d;
  logic [KW-1:0]               k_q, k_d;
  logic [CHW-1:0]              ch_q, ch_d;

  logic                        accept, cfgWrite, decision;
  logic [NIW-1:0]              nodeIdx;
  logic signed [COEFF_WIDTH-1:0] cSel;
  logic signed [IN_WIDTH-1:0]  wSel;
  logic signed [PW-1:0]        prod, scaled;

  assign accept   = (state_q == IDLE) && in_valid;
  assign cfgWrite = (state_q == IDLE) && cfg_we;
  // Only nodes below NODES are ever visited in LOAD/MAC, so the low bits index storage.
  assign nodeIdx  = node_q[NIW-1:0];

  assign cSel   = coeff_q[nodeIdx][k_q];
  assign wSel   = win_q[ch_q][k_q];
  assign prod   = $signed({{IN_WIDTH{cSel[COEFF_WIDTH-1]}}, cSel})
                * $signed({{COEFF_WIDTH{wSel[IN_WIDTH-1]}}, wSel});
  assign scaled = prod >>> (COEFF_WIDTH - 1);

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    node_d   = node_q;
    level_d  = level_q;
    path_d   = path_q;
    k_d      = k_q;
    ch_d     = ch_q;
    decision = acc_q[ACCW-1];
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          ch_d    = in_channel;
          node_d  = '0;
          level_d = '0;
          path_d  = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (leaf_q[nodeIdx]) begin
          state_d = OUT;
        end else begin
          acc_d   = ACCW'(bias_q[nodeIdx]);
          k_d     = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = acc_q + ACCW'(scaled);
        k_d   = k_q + KW'(1);
        if (k_q == KW'(FEATURES - 1)) state_d = DECIDE;
      end
      DECIDE: begin
        for (int i = 0; i < DEPTH; i++) begin
          if (level_q == LW'(i)) path_d[i] = decision;
        end
        node_d  = {node_q[NW-2:0], 1'b0} + NW'(1) + NW'(decision);
        level_d = level_q + LW'(1);
        state_d = (level_d == LW'(DEPTH)) ? OUT : LOAD;
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      node_q  <= '0;
      level_q <= '0;
      path_q  <= '0;
      k_q     <= '0;
      ch_q    <= '0;
      leaf_q  <= '0;
      for (int n = 0; n < NODES; n++) begin
        bias_q[n] <= '0;
        for (int k = 0; k < FEATURES; k++) coeff_q[n][k] <= '0;
      end
      for (int c = 0; c < CHANNELS; c++) begin
        for (int k = 0; k < FEATURES; k++) win_q[c][k] <= '0;
      end
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      node_q  <= node_d;
      level_q <= level_d;
      path_q  <= path_d;
      k_q     <= k_d;
      ch_q    <= ch_d;
      if (cfgWrite) begin
        for (int n = 0; n < NODES; n++) begin
          for (int k = 0; k < FEATURES; k++) begin
            if (cfg_addr == AW'(n * (FEATURES + 1) + k))
              coeff_q[n][k] <= cfg_data[COEFF_WIDTH-1:0];
          end
          if (cfg_addr == AW'(n * (FEATURES + 1) + FEATURES)) begin
            bias_q[n] <= cfg_data[IN_WIDTH-1:0];
            leaf_q[n] <= cfg_data[IN_WIDTH];
          end
        end
      end
      if (accept) begin
        win_q[in_channel][0] <= sample;
        for (int k = 1; k < FEATURES; k++)
          win_q[in_channel][k] <= win_q[in_channel][k-1];
      end
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign cfg_ready   = (state_q == IDLE);
  assign out_valid   = (state_q == OUT);
  assign out_channel = ch_q;
  assign out_path    = path_q;
  assign out_level   = level_q;
  assign out_node    = node_q;

endmodule
